// File: rtl/mem_bus_pkg.sv
// Purpose : shared types and constants for the mem_bus_ctrl RAM sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default RAM read latency, byte-lane count helper.
package mem_bus_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      READ     = 3'd1,
      WRITE    = 3'd2,
      RMW_READ = 3'd3,
      RESP     = 3'd4
   } mem_bus_state_t;

   localparam int MEM_BUS_RD_LATENCY_DEFAULT = 1;

   // Number of byte lanes on a data bus of the given width.
   function automatic int mem_bus_lanes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Purpose : overlay the enabled bytes of a new word onto an old word.
// Latency : combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
//
// Ports: old_word  - word read back from the RAM
//        new_word  - write data from the request
//        be        - one enable per byte lane; 1 selects new_word's byte
//        merged    - resulting word to write back
module mem_byte_merge
   import mem_bus_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]                 old_word,
   input  logic [DATA_WIDTH-1:0]                 new_word,
   input  logic [mem_bus_lanes(DATA_WIDTH)-1:0]  be,
   output logic [DATA_WIDTH-1:0]                 merged
);

   localparam int LANES = mem_bus_lanes(DATA_WIDTH);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) begin
            merged[i*8 +: 8] = new_word[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Purpose : serialise word read/write requests onto a single-port sync RAM.
// Latency : full write rsp at +2, read at +RD_LATENCY+2, RMW write at +RD_LATENCY+3, be==0 / rejected at +1.
// Backpressure: req_ready only in IDLE; a response is held in RESP until rsp_ready.
//
// Optional feature: define MEM_BUS_CTRL_RMW_EN to service partial-byte-enable
// writes by read-modify-write; otherwise they are rejected with rsp_err=1.
//
// Ports: clk, rst (sync, active-high)
//        req_valid/req_ready/req_we/req_addr/req_wdata/req_be - request side
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err                - response side
//        mem_addr/mem_data(inout)/mem_cs/mem_we/mem_oe        - RAM pins
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = MEM_BUS_RD_LATENCY_DEFAULT
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic                                 req_we,
   input  logic [ADDR_WIDTH-1:0]                req_addr,
   input  logic [DATA_WIDTH-1:0]                req_wdata,
   input  logic [mem_bus_lanes(DATA_WIDTH)-1:0] req_be,
   output logic                                 rsp_valid,
   input  logic                                 rsp_ready,
   output logic [DATA_WIDTH-1:0]                rsp_rdata,
   output logic                                 rsp_err,
   output logic [ADDR_WIDTH-1:0]                mem_addr,
   inout  wire  [DATA_WIDTH-1:0]                mem_data,
   output logic                                 mem_cs,
   output logic                                 mem_we,
   output logic                                 mem_oe
);

   localparam int LANES = mem_bus_lanes(DATA_WIDTH);

   // Count value of the last read cycle: READ lasts RD_LATENCY+1 cycles,
   // counting 0..RD_LATENCY, which fits 3 bits for RD_LATENCY up to 7.
   localparam logic [2:0] RD_LAST = 3'(RD_LATENCY);

   mem_bus_state_t        state;
   logic [2:0]            cnt;
   logic [DATA_WIDTH-1:0] wdata_q;   // write data; overwritten by merged word on RMW
   logic                  drive;     // controller owns mem_data (WRITE only)

   // Registered enable keeps the bus glitch-free and released during reset.
   assign mem_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef MEM_BUS_CTRL_RMW_EN
   logic [LANES-1:0]      be_q;
   logic [DATA_WIDTH-1:0] merged;

   // Old word comes straight off the bus so the merge result is ready at
   // the same edge that ends the read phase.
   mem_byte_merge #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_merge (
      .old_word (mem_data),
      .new_word (wdata_q),
      .be       (be_q),
      .merged   (merged)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         wdata_q   <= '0;
         drive     <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_addr  <= '0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
`ifdef MEM_BUS_CTRL_RMW_EN
         be_q      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  mem_addr  <= req_addr;
                  wdata_q   <= req_wdata;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b0;
                  cnt       <= '0;
                  if (!req_we) begin
                     state  <= READ;
                     mem_cs <= 1'b1;
                     mem_oe <= 1'b1;
                  end else if (&req_be) begin
                     state  <= WRITE;
                     mem_cs <= 1'b1;
                     mem_we <= 1'b1;
                     drive  <= 1'b1;
                  end else if (req_be == '0) begin
                     // Nothing to write: answer immediately without touching the RAM.
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
`ifdef MEM_BUS_CTRL_RMW_EN
                     state  <= RMW_READ;
                     mem_cs <= 1'b1;
                     mem_oe <= 1'b1;
                     be_q   <= req_be;
`else
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
`endif
                  end
               end
            end

            READ: begin
               if (cnt == RD_LAST) begin
                  rsp_rdata <= mem_data;
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  mem_cs    <= 1'b0;
                  mem_oe    <= 1'b0;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end

`ifdef MEM_BUS_CTRL_RMW_EN
            RMW_READ: begin
               if (cnt == RD_LAST) begin
                  // Chip select stays high straight into the write-back cycle.
                  wdata_q <= merged;
                  state   <= WRITE;
                  mem_oe  <= 1'b0;
                  mem_we  <= 1'b1;
                  drive   <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
`endif

            WRITE: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               mem_cs    <= 1'b0;
               mem_we    <= 1'b0;
               drive     <= 1'b0;
            end

            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  mem_addr  <= '0;
               end
            end

            default: begin
               state     <= IDLE;
               drive     <= 1'b0;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               mem_addr  <= '0;
               mem_cs    <= 1'b0;
               mem_we    <= 1'b0;
               mem_oe    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Sequencing controller directly upstream of `single_port_sync_ram_large`. It accepts word-addressed read/write requests on a valid/ready interface and drives the RAM's `addr`/`data`/`cs_input`/`we`/`oe` pins, including the shared tri-state data bus. It returns one ordered response per request on a valid/ready interface. It serialises all traffic, holding at most one request in flight and one response buffered.

## Interface
- `ADDR_WIDTH`, 30, word address width; matches the RAM `addr`.
- `DATA_WIDTH`, 32, data width; `DATA_WIDTH/8` byte lanes.
- `RD_LATENCY`, 1, RAM cycles from `cs&oe` sampled to data valid on the bus; range 1..7.

Ports:
- `clk  in  1`  single clock; all logic on rising edge.
- `rst  in  1`  reset, synchronous, active-high.
- `req_valid  in  1`  request present.
- `req_ready  out  1`  controller can accept.
- `req_we  in  1`  1 = write, 0 = read.
- `req_addr  in  ADDR_WIDTH`  word address.
- `req_wdata  in  DATA_WIDTH`  write data.
- `req_be  in  DATA_WIDTH/8`  byte enables; ignored on reads.
- `rsp_valid  out  1`  response present.
- `rsp_ready  in  1`  consumer accepts response.
- `rsp_rdata  out  DATA_WIDTH`  read data; 0 for writes.
- `rsp_err  out  1`  request rejected (see Configuration).
- `mem_addr  out  ADDR_WIDTH`  to RAM `addr`.
- `mem_data  inout  DATA_WIDTH`  to RAM `data`.
- `mem_cs  out  1`  to RAM `cs_input`.
- `mem_we  out  1`  to RAM `we`.
- `mem_oe  out  1`  to RAM `oe`.

## Operation
- States: IDLE, READ, WRITE, RMW_READ, RESP.
- IDLE:
  - `req_ready=1`. On `req_valid&&req_ready`, latch addr/wdata/be/we.
  - Read: go to READ.
  - Write with `be` all-ones: go to WRITE.
  - Write with `be==0`: go to RESP, no memory access, `rsp_err=0`.
  - Write with partial `be`: see Configuration.
- READ:
  - Outputs `mem_cs=1`, `mem_oe=1`, `mem_we=0` for exactly RD_LATENCY+1 cycles, tracked by a 3-bit counter.
  - Capture `mem_data` on the edge ending the last cycle, then go to RESP.
- WRITE:
  - One cycle with `mem_cs=1`, `mem_we=1`, `mem_oe=0`, `mem_data` driven with the (merged) write data.
  - Next state RESP.
- RESP:
  - `rsp_valid=1`, with `rsp_rdata`/`rsp_err` stable.
  - Go to IDLE on `rsp_ready`; otherwise hold indefinitely.
- `mem_data` is driven only in WRITE; hi-Z in every other state and during reset.
- `mem_addr` holds the latched address in every non-IDLE state and 0 in IDLE.
- `req_ready=0` in every state except IDLE, so back-pressure is implicit.
- Reset, any state:
  - Next state IDLE; pending request and response are dropped.
  - Outputs after the reset edge: `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mem_cs=0`, `mem_we=0`, `mem_oe=0`, `mem_addr=0`, `mem_data` hi-Z.
  - A WRITE cycle coinciding with the `rst` edge still commits in the RAM.

## Timing
- Accept on cycle 0.
- Full write: WRITE in cycle 1, `rsp_valid` in cycle 2.
- Read: READ in cycles 1..RD_LATENCY+1, `rsp_valid` in cycle RD_LATENCY+2.
- RMW write: `rsp_valid` in cycle RD_LATENCY+3.
- `be==0` write: `rsp_valid` in cycle 1.
- Peak throughput: one write every 3 cycles with `rsp_ready` tied high; the IDLE cycle after RESP is mandatory.

## Configuration
- `MEM_BUS_CTRL_RMW_EN` defined:
  - A partial-`be` write goes through RMW_READ, which behaves like READ.
  - The controller merges the enabled bytes of `req_wdata` into the captured word, then goes to WRITE.
  - `rsp_err=0`.
- Undefined:
  - A partial-`be` write goes straight to RESP with `rsp_err=1` and no memory access; the RAM is untouched.
  - RMW_READ and the merge logic are absent.

## Structure
- Package `mem_bus_pkg` holds:
  - the state enum `mem_bus_state_t`;
  - `MEM_BUS_RD_LATENCY_DEFAULT=1`;
  - the byte-lane count function.
- Sub-module `mem_byte_merge`: combinational. Inputs are old word, new word and `be`; output is the merged word. It is instantiated only under `MEM_BUS_CTRL_RMW_EN`.

## Test plan
- Reset: drive `rst` high for 2 cycles mid-READ → all outputs at reset values, `mem_data` hi-Z, `req_ready=1` on the next cycle.
- Write then read:
  - Write 0xDEADBEEF to addr 0x0000_0010 with `be=4'hF` → `rsp_valid` at cycle 2, `rsp_err=0`.
  - Read the same address → `rsp_rdata=0xDEADBEEF` at cycle 3 (RD_LATENCY=1).
- Bank boundary: writes to 0x0FFF_FFFF and 0x1000_0000 with distinct data, read back both → each returns its own value.
- Back-pressure: hold `rsp_ready=0` for 5 cycles after a read → `rsp_valid` and `rsp_rdata` stay stable and `req_ready` stays 0. Release → IDLE next cycle.
- Partial write, starting with word 0x11223344 and then writing 0xAABBCCDD with `be=4'b0101`:
  - With the macro: read returns 0x11BB33DD, write response at cycle 4.
  - Without the macro: `rsp_err=1` and the read returns 0x11223344.
- Bus contention: check every cycle that `mem_data` is driven by the controller only when `mem_we=1`, and never while `mem_oe=1`.
